// File: rtl/console_uart_tx_pkg.sv
// Shared definitions for the console UART transmitter: FSM encodings and default baud divider.
package console_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // 50 MHz system clock into a 115200 baud line
    localparam int DEFAULT_CLK_DIV = 434;
    localparam int WORD_W          = 32;

endpackage

// File: rtl/console_uart_tx_fifo.sv
// Synchronous FIFO buffering stdout words ahead of the serialiser; head word is always on dout.
module fifo_console #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // DEPTH is a power of two, so the pointers wrap on their own
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/console_uart_tx.sv
// Buffers stdout words and serialises them as 8N1 frames, BYTES bytes per word, LSB byte first.
module console_uart_tx
    import console_uart_tx_pkg::*;
#(
    parameter int CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int FIFO_DEPTH = 8,
    parameter int BYTES      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] stdout,
    input  logic              stdout_we,
    output logic              tx,
    output logic              busy,
    output logic              full,
    output logic              overflow
);

    localparam int             CW        = $clog2(FIFO_DEPTH);
    localparam logic [15:0]    BAUD_TOP  = 16'(CLK_DIV - 1);
    localparam logic [1:0]     LAST_BYTE = 2'(BYTES - 1);

    uart_state_e       state;
    logic [15:0]       baud;
    logic [2:0]        bit_idx;
    logic [1:0]        byte_idx;
    logic [WORD_W-1:0] shreg;

    logic [WORD_W-1:0] head;
    logic              empty;
    logic [CW:0]       count;
    logic              pop;
    logic              push;
    logic              baud_done;
    logic [2:0]        bit_nxt;
    logic [7:0]        cur_byte;

    assign baud_done = (baud == '0);
    assign bit_nxt   = bit_idx + 3'd1;
    assign cur_byte  = shreg[7:0];

    // Pop only when leaving IDLE or chaining out of the last stop bit of a word
    assign pop  = !empty && ((state == IDLE) ||
                  (state == STOP && baud_done && byte_idx == LAST_BYTE));
    assign push = stdout_we && (!full || pop);
    assign busy = (state != IDLE) || (count != '0);

    fifo_console #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (stdout),
        .pop   (pop),
        .dout  (head),
        .empty (empty),
        .full  (full),
        .count (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            baud     <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            overflow <= 1'b0;
        end else begin
            if (stdout_we && !push) overflow <= 1'b1;
            case (state)
                IDLE: begin
                    if (pop) begin
                        state    <= START;
                        shreg    <= head;
                        byte_idx <= '0;
                        baud     <= BAUD_TOP;
                        tx       <= 1'b0;
                    end
                end
                START: begin
                    if (baud_done) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        baud    <= BAUD_TOP;
                        tx      <= cur_byte[0];
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud <= BAUD_TOP;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_nxt;
                            tx      <= cur_byte[bit_nxt];
                        end
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud <= BAUD_TOP;
                        if (byte_idx != LAST_BYTE) begin
                            byte_idx <= byte_idx + 1'b1;
                            shreg    <= {8'h00, shreg[WORD_W-1:8]};
                            state    <= START;
                            tx       <= 1'b0;
                        end else if (pop) begin
                            shreg    <= head;
                            byte_idx <= '0;
                            state    <= START;
                            tx       <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_console_uart_tx.sv
// Bench for console_uart_tx: three configurations, UART-receiver monitors against byte scoreboards.
module tb_console_uart_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] din [3];
    logic [2:0]  we = '0;
    logic [2:0]  tx_w, busy_w, full_w, ovf_w;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];

    always #5 clk = ~clk;

    console_uart_tx #(.CLK_DIV(4), .FIFO_DEPTH(4), .BYTES(1)) u0 (
        .clk(clk), .rst(rst), .stdout(din[0]), .stdout_we(we[0]),
        .tx(tx_w[0]), .busy(busy_w[0]), .full(full_w[0]), .overflow(ovf_w[0]));

    console_uart_tx #(.CLK_DIV(4), .FIFO_DEPTH(2), .BYTES(4)) u1 (
        .clk(clk), .rst(rst), .stdout(din[1]), .stdout_we(we[1]),
        .tx(tx_w[1]), .busy(busy_w[1]), .full(full_w[1]), .overflow(ovf_w[1]));

    console_uart_tx #(.CLK_DIV(2), .FIFO_DEPTH(2), .BYTES(1)) u2 (
        .clk(clk), .rst(rst), .stdout(din[2]), .stdout_we(we[2]),
        .tx(tx_w[2]), .busy(busy_w[2]), .full(full_w[2]), .overflow(ovf_w[2]));

    function automatic int div_of(input int k);
        return (k == 2) ? 2 : 4;
    endfunction

    function automatic int bytes_of(input int k);
        return (k == 1) ? 4 : 1;
    endfunction

    function automatic int depth_of(input int k);
        return (k == 0) ? 4 : 2;
    endfunction

    // Line level of an 8N1 frame at bit position pos (0 = start, 9 = stop)
    function automatic logic frame_bit(input logic [7:0] b, input int pos);
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return b[pos-1];
    endfunction

    function automatic void qpush(input int k, input logic [7:0] b);
        case (k)
            0:       q0.push_back(b);
            1:       q1.push_back(b);
            default: q2.push_back(b);
        endcase
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [7:0] qpop(input int k);
        case (k)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic void exp_word(input int k, input logic [31:0] w);
        for (int i = 0; i < bytes_of(k); i++) qpush(k, w[8*i +: 8]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [31:0] w);
        din[k] = w;
        we[k]  = 1'b1;
        @(negedge clk);
        we[k]  = 1'b0;
    endtask

    task automatic wait_idle(input int k, input string name);
        int n = 0;
        while (busy_w[k] !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, " idle"}, 32'(busy_w[k]), 0);
    endtask

    // UART receiver: decodes each frame on the line and checks it against the scoreboard
    task automatic uart_mon(input int k);
        int         div;
        logic [7:0] b;
        logic [7:0] e;
        div = div_of(k);
        forever begin
            @(negedge clk);
            if (mon_en && !rst && tx_w[k] === 1'b0) begin
                for (int j = 0; j < 8; j++) begin
                    repeat (div) @(negedge clk);
                    b[j] = tx_w[k];
                end
                repeat (div) @(negedge clk);
                chk($sformatf("mon%0d stop bit", k), 32'(tx_w[k]), 1);
                if (qsize(k) == 0) begin
                    chk($sformatf("mon%0d unexpected frame", k), 32'(b), 32'h1ff);
                end else begin
                    e = qpop(k);
                    chk($sformatf("mon%0d byte", k), 32'(b), 32'(e));
                end
                repeat (div - 1) @(negedge clk);
            end
        end
    endtask

    // Cycle-exact check of a contiguous run of frames; lat = negedges until the start bit appears
    task automatic stream_chk(input int k, input string name, input logic [31:0] bs,
                              input int nfr, output int lat);
        int div;
        int bad;
        div = div_of(k);
        bad = 0;
        lat = 0;
        while (lat < 64) begin
            @(negedge clk);
            lat++;
            if (tx_w[k] === 1'b0) break;
        end
        for (int c = 0; c < nfr * 10 * div; c++) begin
            if (c > 0) @(negedge clk);
            if (tx_w[k] !== frame_bit(bs[8*(c/(10*div)) +: 8], (c/div) % 10)) bad++;
        end
        chk({name, " bit errors"}, 32'(bad), 0);
        @(negedge clk);
        chk({name, " busy after stop"}, 32'(busy_w[k]), 0);
    endtask

    initial begin
        int          lat;
        int          edges;
        logic        prev;
        logic [31:0] w [6];

        for (int k = 0; k < 3; k++) din[k] = '0;
        fork
            uart_mon(0);
            uart_mon(1);
            uart_mon(2);
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst tx%0d", k),   32'(tx_w[k]),   1);
            chk($sformatf("rst busy%0d", k), 32'(busy_w[k]), 0);
            chk($sformatf("rst full%0d", k), 32'(full_w[k]), 0);
            chk($sformatf("rst ovf%0d", k),  32'(ovf_w[k]),  0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of a start bit
        push(0, 32'h55);
        repeat (2) @(negedge clk);
        chk("midframe tx low", 32'(tx_w[0]), 0);
        chk("midframe busy", 32'(busy_w[0]), 1);
        #2 rst = 1'b1;
        #1;
        chk("abort tx", 32'(tx_w[0]), 1);
        chk("abort busy", 32'(busy_w[0]), 0);
        chk("abort ovf", 32'(ovf_w[0]), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        edges = 0;
        prev  = tx_w[0];
        repeat (60) begin
            @(negedge clk);
            if (tx_w[0] !== prev) edges++;
            prev = tx_w[0];
        end
        chk("post-reset tx edges", 32'(edges), 0);
        chk("post-reset busy", 32'(busy_w[0]), 0);
        mon_en = 1'b1;

        // Single character, 4 clocks per bit
        exp_word(0, 32'h41);
        fork
            stream_chk(0, "single", 32'h41, 1, lat);
            push(0, 32'h41);
        join
        chk("single latency", 32'(lat), 2);

        // Word mode: four back-to-back frames, LSB byte first
        exp_word(1, 32'h44434241);
        fork
            stream_chk(1, "word", 32'h44434241, 4, lat);
            push(1, 32'h44434241);
        join
        chk("word latency", 32'(lat), 2);

        // Fill and overflow: first word leaves at once, four stored, sixth dropped
        for (int i = 0; i < 6; i++) w[i] = $urandom;
        for (int i = 0; i < 5; i++) exp_word(0, w[i]);
        for (int i = 0; i < 5; i++) push(0, w[i]);
        chk("fill full", 32'(full_w[0]), 1);
        chk("fill ovf before drop", 32'(ovf_w[0]), 0);
        push(0, w[5]);
        chk("drop full", 32'(full_w[0]), 1);
        chk("drop ovf", 32'(ovf_w[0]), 1);
        wait_idle(0, "fill");
        chk("fill drained full", 32'(full_w[0]), 0);
        chk("ovf sticky", 32'(ovf_w[0]), 1);

        // Strobe on a full FIFO exactly on the stop->start pop edge
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        for (int i = 0; i < 4; i++) exp_word(2, w[i]);
        for (int i = 0; i < 3; i++) push(2, w[i]);
        chk("pwf full", 32'(full_w[2]), 1);
        repeat (17) @(negedge clk);
        chk("pwf full before strobe", 32'(full_w[2]), 1);
        @(negedge clk);
        push(2, w[3]);
        chk("pwf ovf", 32'(ovf_w[2]), 0);
        chk("pwf still full", 32'(full_w[2]), 1);
        wait_idle(2, "pwf");

        // Three words one cycle apart: one continuous 30-bit stream
        for (int i = 0; i < 3; i++) w[i] = $urandom;
        for (int i = 0; i < 3; i++) exp_word(2, w[i]);
        fork
            stream_chk(2, "b2b", {8'h00, w[2][7:0], w[1][7:0], w[0][7:0]}, 3, lat);
            begin
                push(2, w[0]);
                @(negedge clk);
                push(2, w[1]);
                @(negedge clk);
                push(2, w[2]);
            end
        join
        chk("b2b latency", 32'(lat), 2);

        // Random bursts, never deeper than the FIFO can absorb
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 6; r++) begin
                int          len;
                logic [31:0] rw;
                len = $urandom_range(1, depth_of(k));
                for (int i = 0; i < len; i++) begin
                    rw = $urandom;
                    exp_word(k, rw);
                    push(k, rw);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                wait_idle(k, $sformatf("rand%0d", k));
                repeat ($urandom_range(1, 5)) @(negedge clk);
            end
        end

        repeat (20) @(negedge clk);
        for (int k = 0; k < 3; k++)
            chk($sformatf("scoreboard%0d empty", k), 32'(qsize(k)), 0);
        chk("ovf1 clear", 32'(ovf_w[1]), 0);
        chk("ovf2 clear", 32'(ovf_w[2]), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
